// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if : control and function-unit signals of the truth-table sweeper
// rev 1.0
`default_nettype none

interface truth_table_sweeper_if;
  // control master side
  logic        start;
  logic [15:0] expected;
  logic        busy;
  logic        done;
  logic [15:0] truth_tbl;
  logic [4:0]  err_count;
  logic        err_flag;
  logic [3:0]  first_err;
  logic        pass;
  // function unit side
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        s;

  modport master (
    output start, expected, s,
    input  busy, done, truth_tbl, err_count, err_flag, first_err, pass,
    input  a, b, c, d
  );

  modport slave (
    input  start, expected, s,
    output busy, done, truth_tbl, err_count, err_flag, first_err, pass,
    output a, b, c, d
  );
endinterface

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper : drives a 4-input function unit through all 16 vectors and checks its table
// rev 1.0
`default_nettype none

module truth_table_sweeper #(
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  truth_table_sweeper_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] IDX_LAST    = 4'd15;

  state_t      state;
  state_t      next_state;

  logic [3:0]  idx;
  logic [3:0]  settle_cnt;
  logic [15:0] exp_latched;
  logic [15:0] captured;
  logic [4:0]  err_count;
  logic        err_flag;
  logic [3:0]  first_err;
  logic        pass;

  logic        accept;
  logic        sample_en;
  logic        last_vec;
  logic        mismatch;
  logic        busy;
  logic        done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    sample_en  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == SETTLE_LAST) begin
          next_state = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        busy      = 1'b1;
        sample_en = 1'b1;
        next_state = last_vec ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign last_vec = (idx == IDX_LAST);
  assign mismatch = (bus.s != exp_latched[idx]);

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= 4'd0;
      settle_cnt  <= 4'd0;
      exp_latched <= 16'd0;
      captured    <= 16'd0;
      err_count   <= 5'd0;
      err_flag    <= 1'b0;
      first_err   <= 4'd0;
      pass        <= 1'b0;
    end else if (accept) begin
      exp_latched <= bus.expected;
      captured    <= 16'd0;
      err_count   <= 5'd0;
      err_flag    <= 1'b0;
      first_err   <= 4'd0;
      pass        <= 1'b0;
      idx         <= 4'd0;
      settle_cnt  <= 4'd0;
    end else if (sample_en) begin
      captured[idx] <= bus.s;
      if (mismatch) begin
        err_count <= err_count + 5'd1;
        if (!err_flag) begin
          first_err <= idx;
          err_flag  <= 1'b1;
        end
      end
      // pass is resolved on the final sample so it is already valid while done is high
      if (last_vec) begin
        pass <= (err_count == 5'd0) && !mismatch;
      end else begin
        idx        <= idx + 4'd1;
        settle_cnt <= 4'd0;
      end
    end else if (state == ST_SETTLE) begin
      settle_cnt <= settle_cnt + 4'd1;
    end
  end

  // idx itself drives the function unit, so a..d naturally hold while idle
  assign bus.a         = idx[3];
  assign bus.b         = idx[2];
  assign bus.c         = idx[1];
  assign bus.d         = idx[0];
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.truth_tbl = captured;
  assign bus.err_count = err_count;
  assign bus.err_flag  = err_flag;
  assign bus.first_err = first_err;
  assign bus.pass      = pass;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper : directed bench for truth_table_sweeper with SETTLE = 2
// rev 1.0
`default_nettype none

module tb_truth_table_sweeper;

  logic       clk;
  logic       reset;
  logic [1:0] fmode;
  int         checks;
  int         errors;
  int         k_done;
  int         n_done;

  truth_table_sweeper_if bus ();

  truth_table_sweeper #(
    .SETTLE (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // function unit: golden function or stuck-at output
  always_comb begin
    case (fmode)
      2'd1:    bus.s = 1'b1;
      2'd2:    bus.s = 1'b0;
      default: bus.s = (bus.b | bus.c) & (bus.a | ~bus.b | ~bus.c) & (~bus.a | ~bus.b | bus.d);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Start is sampled at the next rising edge (E0); returns at the first falling edge after E0.
  task automatic launch(input logic [15:0] exp_v);
    bus.expected = exp_v;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // k counts rising edges after E0; returns with done visible, or -1 on timeout.
  task automatic wait_done(output int kd);
    kd = -1;
    for (int k = 0; k < 120; k++) begin
      if (bus.done === 1'b1) begin
        kd = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [3:0] abcd();
    return {bus.a, bus.b, bus.c, bus.d};
  endfunction

  initial begin
    clk          = 1'b0;
    reset        = 1'b1;
    fmode        = 2'd0;
    checks       = 0;
    errors       = 0;
    bus.start    = 1'b1;
    bus.expected = 16'hAC3C;

    // reset held with start high
    repeat (2) @(negedge clk);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_abcd",      32'(abcd()),        32'd0);
    check("rst_table",     32'(bus.truth_tbl), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    check("rst_err_flag",  32'(bus.err_flag),  32'd0);
    check("rst_first_err", 32'(bus.first_err), 32'd0);
    check("rst_pass",      32'(bus.pass),      32'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_no_sweep", 32'(bus.busy), 32'd0);
    @(negedge clk);

    // golden sweep with timing of the input vectors
    launch(16'hAC3C);
    k_done = -1;
    for (int k = 0; k < 120; k++) begin
      if (k == 0) begin
        check("gold_busy_k0", 32'(bus.busy), 32'd1);
        check("gold_abcd_k0", 32'(abcd()),   32'd0);
      end
      if (k == 2)  check("gold_abcd_k2",  32'(abcd()), 32'd0);
      if (k == 3)  check("gold_abcd_k3",  32'(abcd()), 32'd1);
      if (k == 23) check("gold_abcd_k23", 32'(abcd()), 32'd7);
      if (k == 45) check("gold_abcd_k45", 32'(abcd()), 32'd15);
      if (bus.done === 1'b1) begin
        k_done = k;
        break;
      end
      @(negedge clk);
    end
    check("gold_latency",   32'(k_done),        32'd48);
    check("gold_busy_done", 32'(bus.busy),      32'd0);
    check("gold_table",     32'(bus.truth_tbl), 32'hAC3C);
    check("gold_pass",      32'(bus.pass),      32'd1);
    check("gold_err_count", 32'(bus.err_count), 32'd0);
    check("gold_err_flag",  32'(bus.err_flag),  32'd0);
    check("gold_first_err", 32'(bus.first_err), 32'd0);
    @(negedge clk);
    check("gold_done_pulse", 32'(bus.done), 32'd0);
    check("gold_pass_held",  32'(bus.pass), 32'd1);

    // single mismatch at vector 0
    launch(16'hAC3D);
    wait_done(k_done);
    check("mm1_latency",   32'(k_done),        32'd48);
    check("mm1_table",     32'(bus.truth_tbl), 32'hAC3C);
    check("mm1_err_count", 32'(bus.err_count), 32'd1);
    check("mm1_first_err", 32'(bus.first_err), 32'd0);
    check("mm1_err_flag",  32'(bus.err_flag),  32'd1);
    check("mm1_pass",      32'(bus.pass),      32'd0);
    @(negedge clk);

    // stuck at 1 against all-zero expectation
    fmode = 2'd1;
    launch(16'h0000);
    wait_done(k_done);
    check("st1_latency",   32'(k_done),        32'd48);
    check("st1_table",     32'(bus.truth_tbl), 32'hFFFF);
    check("st1_err_count", 32'(bus.err_count), 32'd16);
    check("st1_first_err", 32'(bus.first_err), 32'd0);
    check("st1_pass",      32'(bus.pass),      32'd0);
    @(negedge clk);

    // stuck at 0 against the golden table
    fmode = 2'd2;
    launch(16'hAC3C);
    wait_done(k_done);
    check("st0_table",     32'(bus.truth_tbl), 32'h0000);
    check("st0_err_count", 32'(bus.err_count), 32'd8);
    check("st0_first_err", 32'(bus.first_err), 32'd2);
    check("st0_err_flag",  32'(bus.err_flag),  32'd1);
    @(negedge clk);

    // start pulse and expected toggles during a sweep have no effect
    fmode  = 2'd0;
    launch(16'hAC3C);
    n_done = 0;
    k_done = -1;
    for (int k = 0; k <= 48; k++) begin
      if (k == 5)  bus.expected = 16'h0000;
      if (k == 10) bus.start = 1'b1;
      if (k == 11) bus.start = 1'b0;
      if (k == 20) bus.expected = 16'hFFFF;
      if (bus.done === 1'b1) begin
        n_done++;
        k_done = k;
      end
      if (k < 48) @(negedge clk);
    end
    check("hs_done_count", 32'(n_done),        32'd1);
    check("hs_latency",    32'(k_done),        32'd48);
    check("hs_table",      32'(bus.truth_tbl), 32'hAC3C);
    check("hs_err_count",  32'(bus.err_count), 32'd0);
    check("hs_pass",       32'(bus.pass),      32'd1);

    // back-to-back: start in the idle cycle right after done
    @(negedge clk);
    check("b2b_idle", 32'(bus.done), 32'd0);
    launch(16'hAC3D);
    wait_done(k_done);
    check("b2b_latency",   32'(k_done),        32'd48);
    check("b2b_table",     32'(bus.truth_tbl), 32'hAC3C);
    check("b2b_err_count", 32'(bus.err_count), 32'd1);
    check("b2b_first_err", 32'(bus.first_err), 32'd0);
    @(negedge clk);

    // reset while vector 7 is applied
    launch(16'hAC3C);
    repeat (21) @(negedge clk);
    check("mid_abcd_before", 32'(abcd()), 32'd7);
    reset = 1'b1;
    @(negedge clk);
    check("mid_busy",      32'(bus.busy),      32'd0);
    check("mid_done",      32'(bus.done),      32'd0);
    check("mid_abcd",      32'(abcd()),        32'd0);
    check("mid_table",     32'(bus.truth_tbl), 32'd0);
    check("mid_err_count", 32'(bus.err_count), 32'd0);
    check("mid_pass",      32'(bus.pass),      32'd0);
    reset  = 1'b0;
    n_done = 0;
    for (int k = 0; k < 60; k++) begin
      if (bus.done === 1'b1) n_done++;
      @(negedge clk);
    end
    check("mid_no_done", 32'(n_done), 32'd0);
    launch(16'hAC3C);
    wait_done(k_done);
    check("post_latency", 32'(k_done),        32'd48);
    check("post_table",   32'(bus.truth_tbl), 32'hAC3C);
    check("post_pass",    32'(bus.pass),      32'd1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
